// File: rtl/mdio_transmisor_if.sv
// mdio_transmisor_if: host request, read result and MDIO line signals.
// master: seen by mdio_transmisor; slave: seen by the host / PHY side.
interface mdio_transmisor_if;
    logic        MDIO_START;
    logic [31:0] T_DATA;
    logic        MDIO_IN;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        BUSY;

    modport master (
        input  MDIO_START, T_DATA, MDIO_IN,
        output MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, BUSY
    );

    modport slave (
        output MDIO_START, T_DATA, MDIO_IN,
        input  MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, BUSY
    );
endinterface

// File: rtl/mdio_transmisor.sv
// mdio_transmisor: MDIO management master. Ports: CLK, reset (async, high),
// bus (master modport): MDIO_START/T_DATA request, MDC/MDIO_OUT/MDIO_OE line,
// MDIO_IN return data, RD_DATA/DATA_RDY read result, BUSY.
// Optional macro MDIO_PREAMBLE_EN: prefix every frame with 32 driven ones.
module mdio_transmisor (
    input  logic              CLK,
    input  logic              reset,
    mdio_transmisor_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
`ifdef MDIO_PREAMBLE_EN
        PRE,
`endif
        SEND,
        RECV,
        DONE
    } state_t;

    state_t      state, state_n;
    logic        mdc;
    logic [31:0] sh, sh_n;
    logic [5:0]  cnt, cnt_n;
    logic        out, out_n;
    logic        oe, oe_n;
    logic [15:0] rd, rd_n;
    logic        is_rd, is_rd_n;
    logic        fall;
    logic [5:0]  last;
    logic        op_ok;

    // MDC is high now, so this edge takes it 1->0
    assign fall  = mdc;
    assign last  = is_rd ? 6'd15 : 6'd31;
    assign op_ok = (bus.T_DATA[29:28] == 2'b01) ||
                   (bus.T_DATA[29:28] == 2'b10);

    assign bus.MDC      = mdc;
    assign bus.MDIO_OUT = out;
    assign bus.MDIO_OE  = oe;
    assign bus.RD_DATA  = rd;
    assign bus.DATA_RDY = (state == DONE) && is_rd;
    assign bus.BUSY     = (state != IDLE);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mdc   <= 1'b0;
            sh    <= '0;
            cnt   <= '0;
            out   <= 1'b0;
            oe    <= 1'b0;
            rd    <= '0;
            is_rd <= 1'b0;
        end else begin
            state <= state_n;
            mdc   <= ~mdc;
            sh    <= sh_n;
            cnt   <= cnt_n;
            out   <= out_n;
            oe    <= oe_n;
            rd    <= rd_n;
            is_rd <= is_rd_n;
        end
    end

    // oe low inside SEND/PRE means the first period has not started yet;
    // cnt holds the index of the period currently on the line.
    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        out_n   = out;
        oe_n    = oe;
        rd_n    = rd;
        is_rd_n = is_rd;
        unique case (state)
            IDLE: begin
                out_n = 1'b0;
                oe_n  = 1'b0;
                if (bus.MDIO_START && op_ok) begin
                    sh_n    = bus.T_DATA;
                    is_rd_n = bus.T_DATA[29];
                    cnt_n   = '0;
`ifdef MDIO_PREAMBLE_EN
                    state_n = PRE;
`else
                    state_n = SEND;
`endif
                end
            end
`ifdef MDIO_PREAMBLE_EN
            PRE: begin
                if (fall) begin
                    if (!oe) begin
                        oe_n  = 1'b1;
                        out_n = 1'b1;
                    end else if (cnt == 6'd31) begin
                        out_n   = sh[31];
                        sh_n    = {sh[30:0], 1'b0};
                        cnt_n   = '0;
                        state_n = SEND;
                    end else begin
                        cnt_n = cnt + 6'd1;
                    end
                end
            end
`endif
            SEND: begin
                if (fall) begin
                    if (!oe) begin
                        oe_n  = 1'b1;
                        out_n = sh[31];
                        sh_n  = {sh[30:0], 1'b0};
                        cnt_n = '0;
                    end else if (cnt == last) begin
                        oe_n    = 1'b0;
                        out_n   = 1'b0;
                        cnt_n   = '0;
                        state_n = is_rd ? RECV : DONE;
                    end else begin
                        out_n = sh[31];
                        sh_n  = {sh[30:0], 1'b0};
                        cnt_n = cnt + 6'd1;
                    end
                end
            end
            RECV: begin
                if (fall) begin
                    sh_n = {sh[30:0], bus.MDIO_IN};
                    if (cnt == 6'd15) begin
                        rd_n    = {sh[14:0], bus.MDIO_IN};
                        state_n = DONE;
                    end else begin
                        cnt_n = cnt + 6'd1;
                    end
                end
            end
            DONE: begin
                oe_n    = 1'b0;
                out_n   = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mdio_transmisor.sv
// tb_mdio_transmisor: self-checking bench for mdio_transmisor.
// Observes MDIO at MDC rise edges and acts as the PHY for reads.
module tb_mdio_transmisor;
    localparam int PRE = `ifdef MDIO_PREAMBLE_EN 32 `else 0 `endif;

    logic CLK = 1'b0;
    logic reset = 1'b1;

    mdio_transmisor_if bus();

    mdio_transmisor dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] last_rd;

    logic [63:0] got_bits;
    int          nbits;
    int          oe_cyc;
    int          rdy_cnt;
    logic [15:0] rdy_val;
    int          first_oe;
    int          align_err;
    logic        busy_at1;
    bit          finished;

    function automatic bit is_read(input logic [31:0] td);
        return td[29:28] == 2'b10;
    endfunction

    function automatic int exp_n(input logic [31:0] td);
        return PRE + (is_read(td) ? 16 : 32);
    endfunction

    function automatic logic [63:0] exp_bits(input logic [31:0] td);
        logic [63:0] v = '0;
        int lo = is_read(td) ? 16 : 0;
        for (int i = 0; i < PRE; i++) v = {v[62:0], 1'b1};
        for (int i = 31; i >= lo; i--) v = {v[62:0], td[i]};
        return v;
    endfunction

    // Runs one frame from the capture edge until BUSY falls.
    // stop_cyc: cycle at which MDIO_START is dropped (0 = keep it high).
    // td_after: T_DATA value applied right after the capture edge.
    // abort_cyc: cycle at which reset is asserted (0 = never).
    task automatic observe(input logic [15:0] phy, input int stop_cyc,
                           input logic [31:0] td_after, input int abort_cyc);
        int   cyc = 0;
        int   k = 0;
        logic pm, po, pe, rise, seen_busy;
        got_bits = '0; nbits = 0; oe_cyc = 0; rdy_cnt = 0; rdy_val = '0;
        first_oe = -1; align_err = 0; busy_at1 = 1'b0; finished = 0;
        seen_busy = 1'b0;
        pm = bus.MDC; po = bus.MDIO_OUT; pe = bus.MDIO_OE;
        while (cyc < 700 && !finished) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (cyc == 1) begin
                bus.T_DATA = td_after;
                busy_at1 = bus.BUSY;
            end
            if (cyc == stop_cyc) bus.MDIO_START = 1'b0;
            rise = bus.MDC && !pm;
            if (rise && (bus.MDIO_OUT !== po || bus.MDIO_OE !== pe))
                align_err++;
            if (bus.MDIO_OE) begin
                oe_cyc++;
                if (first_oe < 0) first_oe = cyc;
            end
            if (rise && bus.MDIO_OE) begin
                got_bits = {got_bits[62:0], bus.MDIO_OUT};
                nbits++;
            end
            if (rise && !bus.MDIO_OE && oe_cyc > 0 && k < 16) begin
                bus.MDIO_IN = phy[15-k];
                k++;
            end
            if (bus.DATA_RDY) begin
                rdy_cnt++;
                rdy_val = bus.RD_DATA;
            end
            if (bus.BUSY) seen_busy = 1'b1;
            else if (seen_busy) finished = 1;
            if (cyc == abort_cyc) begin
                reset = 1'b1;
                finished = 1;
            end
            pm = bus.MDC; po = bus.MDIO_OUT; pe = bus.MDIO_OE;
        end
        tests_run++;
        if (!finished) begin
            tests_failed++;
            $display("FAIL observe_timeout cycles=%0d required frame end", cyc);
        end
    endtask

    task automatic test_reset();
        bus.MDIO_START = 1'b0;
        bus.T_DATA = '0;
        bus.MDIO_IN = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge CLK);
        tests_run++;
        if ({bus.MDC, bus.MDIO_OUT, bus.MDIO_OE, bus.RD_DATA,
             bus.DATA_RDY, bus.BUSY} !== 21'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%h required=0",
                     {bus.MDC, bus.MDIO_OUT, bus.MDIO_OE, bus.RD_DATA,
                      bus.DATA_RDY, bus.BUSY});
        end
        reset = 1'b0;
        last_rd = 16'h0000;
        @(posedge CLK);
        #1;
        tests_run++;
        if (bus.MDC !== 1'b1 || bus.BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release mdc=%b busy=%b required mdc=1 busy=0",
                     bus.MDC, bus.BUSY);
        end
    endtask

    task automatic test_write();
        logic [31:0] td = 32'h50A3BEEF;
        bus.T_DATA = td;
        bus.MDIO_START = 1'b1;
        observe(16'h0, 1, td, 0);
        tests_run++;
        if (busy_at1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_busy got=%b required=1", busy_at1);
        end
        tests_run++;
        if (nbits != exp_n(td) || got_bits !== exp_bits(td)) begin
            tests_failed++;
            $display("FAIL write_bits got=%0d:%h required=%0d:%h",
                     nbits, got_bits, exp_n(td), exp_bits(td));
        end
        tests_run++;
        if (oe_cyc != 2 * exp_n(td)) begin
            tests_failed++;
            $display("FAIL write_oe_len got=%0d required=%0d",
                     oe_cyc, 2 * exp_n(td));
        end
        tests_run++;
        if (rdy_cnt != 0 || align_err != 0) begin
            tests_failed++;
            $display("FAIL write_rdy_align rdy=%0d align=%0d required 0 0",
                     rdy_cnt, align_err);
        end
        tests_run++;
        if (first_oe < 2 || first_oe > 3) begin
            tests_failed++;
            $display("FAIL write_latency got=%0d required 2..3", first_oe);
        end
    endtask

    task automatic test_read();
        logic [31:0] td = 32'h60A20000;
        logic [15:0] phy = 16'hA5C3;
        bus.T_DATA = td;
        bus.MDIO_START = 1'b1;
        observe(phy, 1, td, 0);
        tests_run++;
        if (nbits != exp_n(td) || got_bits !== exp_bits(td)) begin
            tests_failed++;
            $display("FAIL read_bits got=%0d:%h required=%0d:%h",
                     nbits, got_bits, exp_n(td), exp_bits(td));
        end
        tests_run++;
        if (oe_cyc != 2 * exp_n(td)) begin
            tests_failed++;
            $display("FAIL read_oe_len got=%0d required=%0d",
                     oe_cyc, 2 * exp_n(td));
        end
        tests_run++;
        if (rdy_cnt != 1 || rdy_val !== phy) begin
            tests_failed++;
            $display("FAIL read_data rdy=%0d val=%h required 1 %h",
                     rdy_cnt, rdy_val, phy);
        end
        tests_run++;
        if (bus.RD_DATA !== phy || align_err != 0) begin
            tests_failed++;
            $display("FAIL read_hold rd=%h align=%0d required %h 0",
                     bus.RD_DATA, align_err, phy);
        end
        last_rd = phy;
    endtask

    task automatic test_invalid_op();
        int errs = 0;
        logic pm;
        logic [31:0] td;
        for (int j = 0; j < 2; j++) begin
            td = $urandom;
            td[29:28] = (j == 0) ? 2'b11 : 2'b00;
            bus.T_DATA = td;
            bus.MDIO_START = 1'b1;
            pm = bus.MDC;
            repeat (6) begin
                @(posedge CLK);
                #1;
                if (bus.BUSY !== 1'b0 || bus.MDIO_OE !== 1'b0 ||
                    bus.MDC === pm)
                    errs++;
                pm = bus.MDC;
            end
        end
        bus.MDIO_START = 1'b0;
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL invalid_op bad_cycles=%0d required=0", errs);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] td1 = $urandom;
        logic [31:0] td2 = $urandom;
        logic [15:0] phy = 16'($urandom);
        td1[29:28] = 2'b01;
        td2[29:28] = 2'b10;
        bus.T_DATA = td1;
        bus.MDIO_START = 1'b1;
        observe(16'h0, 0, td2, 0);
        tests_run++;
        if (nbits != exp_n(td1) || got_bits !== exp_bits(td1)) begin
            tests_failed++;
            $display("FAIL busy_ignore got=%0d:%h required=%0d:%h",
                     nbits, got_bits, exp_n(td1), exp_bits(td1));
        end
        tests_run++;
        if (bus.RD_DATA !== last_rd || rdy_cnt != 0) begin
            tests_failed++;
            $display("FAIL rd_hold_write rd=%h rdy=%0d required %h 0",
                     bus.RD_DATA, rdy_cnt, last_rd);
        end
        observe(phy, 2, td2, 0);
        tests_run++;
        if (busy_at1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_restart busy=%b required=1", busy_at1);
        end
        tests_run++;
        if (nbits != exp_n(td2) || got_bits !== exp_bits(td2) ||
            rdy_val !== phy || rdy_cnt != 1) begin
            tests_failed++;
            $display("FAIL b2b_frame bits=%h rd=%h rdy=%0d required %h %h 1",
                     got_bits, rdy_val, rdy_cnt, exp_bits(td2), phy);
        end
        last_rd = phy;
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] td = $urandom;
        logic [15:0] phy = 16'($urandom) | 16'h0001;
        td[29:28] = 2'b10;
        bus.T_DATA = td;
        bus.MDIO_START = 1'b1;
        observe(phy, 1, td, 2 + 2 * (PRE + 20));
        #1;
        tests_run++;
        if ({bus.MDC, bus.MDIO_OUT, bus.MDIO_OE, bus.RD_DATA,
             bus.DATA_RDY, bus.BUSY} !== 21'd0 || rdy_cnt != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_read out=%h rdy=%0d required 0 0",
                     {bus.MDC, bus.MDIO_OUT, bus.MDIO_OE, bus.RD_DATA,
                      bus.DATA_RDY, bus.BUSY}, rdy_cnt);
        end
        #2;
        reset = 1'b0;
        last_rd = 16'h0000;
        phy = 16'($urandom);
        bus.MDIO_START = 1'b1;
        observe(phy, 1, td, 0);
        tests_run++;
        if (got_bits !== exp_bits(td) || rdy_cnt != 1 ||
            bus.RD_DATA !== phy) begin
            tests_failed++;
            $display("FAIL read_after_reset bits=%h rd=%h rdy=%0d required %h %h 1",
                     got_bits, bus.RD_DATA, rdy_cnt, exp_bits(td), phy);
        end
        last_rd = phy;
    endtask

    task automatic test_random();
        logic [31:0] td;
        logic [15:0] phy;
        logic [15:0] want_rd;
        for (int it = 0; it < 12; it++) begin
            td = $urandom;
            td[29:28] = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            phy = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            #1;
            bus.T_DATA = td;
            bus.MDIO_START = 1'b1;
            observe(phy, 1, 32'($urandom), 0);
            want_rd = is_read(td) ? phy : last_rd;
            tests_run++;
            if (nbits != exp_n(td) || got_bits !== exp_bits(td)) begin
                tests_failed++;
                $display("FAIL rand_bits it=%0d got=%0d:%h required=%0d:%h",
                         it, nbits, got_bits, exp_n(td), exp_bits(td));
            end
            tests_run++;
            if (oe_cyc != 2 * exp_n(td) || align_err != 0) begin
                tests_failed++;
                $display("FAIL rand_oe it=%0d oe=%0d align=%0d required %0d 0",
                         it, oe_cyc, align_err, 2 * exp_n(td));
            end
            tests_run++;
            if (bus.RD_DATA !== want_rd ||
                rdy_cnt != (is_read(td) ? 1 : 0)) begin
                tests_failed++;
                $display("FAIL rand_rd it=%0d rd=%h rdy=%0d required %h %0d",
                         it, bus.RD_DATA, rdy_cnt, want_rd,
                         is_read(td) ? 1 : 0);
            end
            last_rd = want_rd;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_invalid_op();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
